signal_tracker_recall_requester: RTL

Initiator for the signal tracker value-recall handshake. Clients submit "value of the tracked signal k cycles before this request" queries over valid/ready; the block queues them and compensates each query's cycles-back for queueing delay. It drives recalculate_back_cycle / cycles_back_to_recall, consumes data_valid / signal_recall, and returns one response per query with a status code. Sits between trace-analysis logic and a value-recall tracker instance.

---
 rtl/signal_tracker_recall_requester.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/signal_tracker_recall_requester.sv
// Requester side of the signal-tracker value-recall handshake: queues "k cycles ago" queries,
// compensates each for queueing delay, drives the tracker and returns one status-coded response.
module signal_tracker_recall_requester #(
  parameter int unsigned TRACKED_SIGNAL_WIDTH = 32,
  parameter int unsigned BUFFER_WIDTH         = 8,
  parameter int unsigned FIFO_DEPTH           = 4,
  parameter int unsigned TIMEOUT              = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [$clog2(BUFFER_WIDTH):0]     req_cycles_back,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [TRACKED_SIGNAL_WIDTH-1:0]   resp_value,
  output logic [1:0]                        resp_status,
  output logic                              recalculate_back_cycle,
  output logic [$clog2(BUFFER_WIDTH):0]     cycles_back_to_recall,
  input  logic                              data_valid,
  input  logic [TRACKED_SIGNAL_WIDTH-1:0]   signal_recall
);

  localparam int unsigned CbW    = $clog2(BUFFER_WIDTH) + 1;
  localparam int unsigned AgeMax = 2 * BUFFER_WIDTH;
  localparam int unsigned AgeW   = $clog2(AgeMax) + 1;
  localparam int unsigned EW     = AgeW + 1;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned TmoW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusTooOld  = 2'b01;
  localparam logic [1:0] StatusTimeout = 2'b10;
  localparam logic [1:0] StatusBadArg  = 2'b11;

  typedef enum logic [2:0] {StIdle, StFlush, StIssue, StWait, StAck, StResp} state_e;

  state_e                    state_q, state_d;
  logic [CbW-1:0]            k_q   [FIFO_DEPTH];
  logic [AgeW-1:0]           age_q [FIFO_DEPTH];
  logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]           count_q;
  logic [TmoW-1:0]           tmo_q, tmo_d;
  logic [CbW-1:0]            cb_q, cb_d;
  logic [TRACKED_SIGNAL_WIDTH-1:0] value_q, value_d;
  logic [1:0]                status_q, status_d;
  logic                      recalc_q, recalc_d;
  logic                      resp_valid_q, resp_valid_d;

  logic                      full, empty, push, pop;
  logic [CbW-1:0]            head_k;
  logic [EW-1:0]             eff;

  assign full   = (count_q == CntW'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign push   = req_valid && req_ready;
  assign head_k = k_q[rd_ptr_q];
  // Offset seen by the tracker when it samples at the end of the ISSUE cycle.
  assign eff    = EW'(head_k) + EW'(age_q[rd_ptr_q]) + EW'(1);

  assign req_ready              = !full;
  assign resp_valid             = resp_valid_q;
  assign resp_value             = value_q;
  assign resp_status            = status_q;
  assign recalculate_back_cycle = recalc_q;
  assign cycles_back_to_recall  = cb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        k_q[i]   <= '0;
        age_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (age_q[i] != AgeW'(AgeMax)) age_q[i] <= age_q[i] + AgeW'(1);
      end
      if (push) begin
        k_q[wr_ptr_q]   <= req_cycles_back;
        age_q[wr_ptr_q] <= AgeW'(1);
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    tmo_d    = tmo_q;
    cb_d     = cb_q;
    value_d  = value_q;
    status_d = status_q;
    unique case (state_q)
      StIdle: begin
        if (data_valid) begin
          state_d = StFlush;
        end else if (!empty) begin
          pop = 1'b1;
          if (head_k == '0) begin
            status_d = StatusBadArg;
            value_d  = '0;
            state_d  = StResp;
          end else if (eff > EW'(BUFFER_WIDTH - 1)) begin
            status_d = StatusTooOld;
            value_d  = '0;
            state_d  = StResp;
          end else begin
            cb_d    = eff[CbW-1:0];
            state_d = StIssue;
          end
        end
      end
      StFlush: state_d = StIdle;
      StIssue: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (data_valid) begin
          value_d  = signal_recall;
          status_d = StatusOk;
          state_d  = StAck;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          value_d  = '0;
          status_d = StatusTimeout;
          state_d  = StResp;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      // Second pulse clears the tracker's data_valid; cycles_back stays put.
      StAck: state_d = StResp;
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    recalc_d     = (state_d == StIssue) || (state_d == StFlush) || (state_d == StAck);
    resp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tmo_q        <= '0;
      cb_q         <= '0;
      value_q      <= '0;
      status_q     <= StatusOk;
      recalc_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      cb_q         <= cb_d;
      value_q      <= value_d;
      status_q     <= status_d;
      recalc_q     <= recalc_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule
